// File: rtl/rvc_compressor.sv
// Streaming RV32I -> RVC compressor: re-encodes compressible instructions as 16-bit halfwords
// and packs the mixed 16/32-bit stream into little-endian 32-bit words (lower halfword first).
module rvc_compressor #(
    parameter bit          ENABLE_COMPRESS = 1'b1,
    parameter int          COUNT_W         = 16,
    parameter logic [15:0] PAD_HALF        = 16'h0001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_ins,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic               err_illegal,
    output logic [COUNT_W-1:0] cnt_in,
    output logic [COUNT_W-1:0] cnt_comp
);
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [31:0] INS_EBREAK = 32'h00100073;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t               r_state, w_state_next;
    logic                 r_out_valid, w_out_valid_next;
    logic [31:0]          r_out_data, w_out_data_next;
    logic                 r_hold_valid, w_hold_valid_next;
    logic [15:0]          r_hold, w_hold_next;
    logic                 r_err_illegal;
    logic [COUNT_W-1:0]   r_cnt_in, r_cnt_comp;

    logic                 w_in_fire, w_out_fire, w_legal;
    logic                 w_comp_ok;
    logic [15:0]          w_comp_half;

    logic [6:0]           w_opc, w_f7;
    logic [4:0]           w_rd, w_rs1, w_rs2;
    logic [2:0]           w_f3;
    logic [11:0]          w_imm_i, w_imm_s;
    logic                 w_rd_p, w_rs1_p, w_rs2_p;
    logic                 w_imm_i6, w_imm_sp10, w_lui6;

    assign w_opc   = in_ins[6:0];
    assign w_rd    = in_ins[11:7];
    assign w_f3    = in_ins[14:12];
    assign w_rs1   = in_ins[19:15];
    assign w_rs2   = in_ins[24:20];
    assign w_f7    = in_ins[31:25];
    assign w_imm_i = in_ins[31:20];
    assign w_imm_s = {in_ins[31:25], in_ins[11:7]};

    // Compact register fields (x8..x15) and the signed-range tests shared by several encodings.
    assign w_rd_p     = (w_rd[4:3] == 2'b01);
    assign w_rs1_p    = (w_rs1[4:3] == 2'b01);
    assign w_rs2_p    = (w_rs2[4:3] == 2'b01);
    assign w_imm_i6   = (w_imm_i[11:5] == 7'h00) || (w_imm_i[11:5] == 7'h7F);
    assign w_imm_sp10 = (w_imm_i[11:9] == 3'b000) || (w_imm_i[11:9] == 3'b111);
    assign w_lui6     = (in_ins[31:17] == 15'h0000) || (in_ins[31:17] == 15'h7FFF);

    assign w_legal    = (in_ins[1:0] == 2'b11);
    assign in_ready   = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_comp_ok   = 1'b0;
        w_comp_half = 16'h0000;
        if (ENABLE_COMPRESS && w_legal) begin
            if (in_ins == INS_EBREAK) begin
                w_comp_ok   = 1'b1;
                w_comp_half = 16'h9002;
            end else begin
                case (w_opc)
                    OPC_OP_IMM: begin
                        case (w_f3)
                            3'b000: begin
                                if (w_rs1 == 5'd2 && w_rd_p && w_imm_i[1:0] == 2'b00 &&
                                    w_imm_i[11:10] == 2'b00 && w_imm_i != 12'd0) begin
                                    w_comp_ok   = 1'b1;
                                    w_comp_half = {3'b000, w_imm_i[5:4], w_imm_i[9:6], w_imm_i[2],
                                                   w_imm_i[3], w_rd[2:0], 2'b00};
                                end else if (w_rd == 5'd2 && w_rs1 == 5'd2 && w_imm_i[3:0] == 4'h0 &&
                                             w_imm_i != 12'd0 && w_imm_sp10) begin
                                    w_comp_ok   = 1'b1;
                                    w_comp_half = {3'b011, w_imm_i[9], 5'd2, w_imm_i[4], w_imm_i[6],
                                                   w_imm_i[8:7], w_imm_i[5], 2'b01};
                                end else if (w_rd != 5'd0 && w_rd == w_rs1 && w_imm_i != 12'd0 && w_imm_i6) begin
                                    w_comp_ok   = 1'b1;
                                    w_comp_half = {3'b000, w_imm_i[5], w_rd, w_imm_i[4:0], 2'b01};
                                end else if (w_rd != 5'd0 && w_rs1 == 5'd0 && w_imm_i6) begin
                                    w_comp_ok   = 1'b1;
                                    w_comp_half = {3'b010, w_imm_i[5], w_rd, w_imm_i[4:0], 2'b01};
                                end
                            end
                            3'b001: begin
                                if (w_f7 == 7'd0 && w_rd != 5'd0 && w_rd == w_rs1 && w_rs2 != 5'd0) begin
                                    w_comp_ok   = 1'b1;
                                    w_comp_half = {4'b0000, w_rd, w_rs2, 2'b10};
                                end
                            end
                            3'b101: begin
                                if (w_rd_p && w_rd == w_rs1 && (w_f7 == 7'b0000000 || w_f7 == 7'b0100000)) begin
                                    w_comp_ok   = 1'b1;
                                    w_comp_half = {4'b1000, 1'b0, w_f7[5], w_rd[2:0], w_rs2, 2'b01};
                                end
                            end
                            3'b111: begin
                                if (w_rd_p && w_rd == w_rs1 && w_imm_i6) begin
                                    w_comp_ok   = 1'b1;
                                    w_comp_half = {3'b100, w_imm_i[5], 2'b10, w_rd[2:0], w_imm_i[4:0], 2'b01};
                                end
                            end
                            default: ;
                        endcase
                    end
                    OPC_LUI: begin
                        if (w_rd != 5'd0 && w_rd != 5'd2 && in_ins[31:12] != 20'd0 && w_lui6) begin
                            w_comp_ok   = 1'b1;
                            w_comp_half = {3'b011, in_ins[17], w_rd, in_ins[16:12], 2'b01};
                        end
                    end
                    OPC_LOAD: begin
                        if (w_f3 == 3'b010) begin
                            if (w_rd_p && w_rs1_p && w_imm_i[1:0] == 2'b00 && w_imm_i[11:7] == 5'd0) begin
                                w_comp_ok   = 1'b1;
                                w_comp_half = {3'b010, w_imm_i[5:3], w_rs1[2:0], w_imm_i[2], w_imm_i[6],
                                               w_rd[2:0], 2'b00};
                            end else if (w_rs1 == 5'd2 && w_rd != 5'd0 && w_imm_i[1:0] == 2'b00 &&
                                         w_imm_i[11:8] == 4'd0) begin
                                w_comp_ok   = 1'b1;
                                w_comp_half = {3'b010, w_imm_i[5], w_rd, w_imm_i[4:2], w_imm_i[7:6], 2'b10};
                            end
                        end
                    end
                    OPC_STORE: begin
                        if (w_f3 == 3'b010) begin
                            if (w_rs1_p && w_rs2_p && w_imm_s[1:0] == 2'b00 && w_imm_s[11:7] == 5'd0) begin
                                w_comp_ok   = 1'b1;
                                w_comp_half = {3'b110, w_imm_s[5:3], w_rs1[2:0], w_imm_s[2], w_imm_s[6],
                                               w_rs2[2:0], 2'b00};
                            end else if (w_rs1 == 5'd2 && w_imm_s[1:0] == 2'b00 && w_imm_s[11:8] == 4'd0) begin
                                w_comp_ok   = 1'b1;
                                w_comp_half = {3'b110, w_imm_s[5:2], w_imm_s[7:6], w_rs2, 2'b10};
                            end
                        end
                    end
                    OPC_OP: begin
                        if (w_rd_p && w_rd == w_rs1 && w_rs2_p && w_f3 == 3'b000 && w_f7 == 7'b0100000) begin
                            w_comp_ok   = 1'b1;
                            w_comp_half = {6'b100011, w_rd[2:0], 2'b00, w_rs2[2:0], 2'b01};
                        end else if (w_rd_p && w_rd == w_rs1 && w_rs2_p && w_f7 == 7'd0 &&
                                     (w_f3 == 3'b100 || w_f3 == 3'b110 || w_f3 == 3'b111)) begin
                            w_comp_ok   = 1'b1;
                            w_comp_half = {6'b100011, w_rd[2:0], w_f3[2:1] ^ {1'b0, w_f3[0]} ^ 2'b11,
                                           w_rs2[2:0], 2'b01};
                            if (w_f3 == 3'b100) w_comp_half[6:5] = 2'b01;
                            else if (w_f3 == 3'b110) w_comp_half[6:5] = 2'b10;
                            else w_comp_half[6:5] = 2'b11;
                        end else if (w_f3 == 3'b000 && w_f7 == 7'd0 && w_rd != 5'd0 && w_rs2 != 5'd0) begin
                            if (w_rs1 == 5'd0) begin
                                w_comp_ok   = 1'b1;
                                w_comp_half = {4'b1000, w_rd, w_rs2, 2'b10};
                            end else if (w_rs1 == w_rd) begin
                                w_comp_ok   = 1'b1;
                                w_comp_half = {4'b1001, w_rd, w_rs2, 2'b10};
                            end
                        end
                    end
                    OPC_JALR: begin
                        if (w_f3 == 3'b000 && w_imm_i == 12'd0 && w_rs1 != 5'd0 && w_rd[4:1] == 4'd0) begin
                            w_comp_ok   = 1'b1;
                            w_comp_half = {3'b100, w_rd[0], w_rs1, 5'd0, 2'b10};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Packing and flush sequencing; the output register is only written when it is free.
    always_comb begin
        w_state_next      = r_state;
        w_out_valid_next  = r_out_valid;
        w_out_data_next   = r_out_data;
        w_hold_valid_next = r_hold_valid;
        w_hold_next       = r_hold;
        if (w_out_fire) w_out_valid_next = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_in_fire) begin
                    if (w_comp_ok) begin
                        if (r_hold_valid) begin
                            w_out_data_next   = {w_comp_half, r_hold};
                            w_out_valid_next  = 1'b1;
                            w_hold_valid_next = 1'b0;
                        end else begin
                            w_hold_next       = w_comp_half;
                            w_hold_valid_next = 1'b1;
                        end
                    end else begin
                        w_out_valid_next = 1'b1;
                        if (r_hold_valid) begin
                            w_out_data_next = {in_ins[15:0], r_hold};
                            w_hold_next     = in_ins[31:16];
                        end else begin
                            w_out_data_next = in_ins;
                        end
                    end
                    if (in_last && w_hold_valid_next) w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!r_out_valid || out_ready) begin
                    w_out_data_next   = {PAD_HALF, r_hold};
                    w_out_valid_next  = 1'b1;
                    w_hold_valid_next = 1'b0;
                    w_state_next      = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_out_valid   <= 1'b0;
            r_out_data    <= 32'd0;
            r_hold_valid  <= 1'b0;
            r_hold        <= 16'd0;
            r_err_illegal <= 1'b0;
            r_cnt_in      <= '0;
            r_cnt_comp    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_out_valid  <= w_out_valid_next;
            r_out_data   <= w_out_data_next;
            r_hold_valid <= w_hold_valid_next;
            r_hold       <= w_hold_next;
            if (w_in_fire) begin
                r_cnt_in <= r_cnt_in + COUNT_W'(1);
                if (w_comp_ok) r_cnt_comp <= r_cnt_comp + COUNT_W'(1);
                if (!w_legal) r_err_illegal <= 1'b1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign err_illegal = r_err_illegal;
    assign cnt_in      = r_cnt_in;
    assign cnt_comp    = r_cnt_comp;

endmodule

// File: tb/tb_rvc_compressor.sv
// Scoreboard bench for rvc_compressor: directed instructions with hand-encoded expected words,
// one instance with compression enabled and one pass-through instance.
module tb_rvc_compressor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_err;
    logic [31:0] a_in_ins, a_out_data;
    logic [15:0] a_cnt_in, a_cnt_comp;
    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_err;
    logic [31:0] b_in_ins, b_out_data;
    logic [15:0] b_cnt_in, b_cnt_comp;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];

    rvc_compressor #(.ENABLE_COMPRESS(1'b1), .COUNT_W(16), .PAD_HALF(16'h0001)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ins(a_in_ins), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .err_illegal(a_err), .cnt_in(a_cnt_in), .cnt_comp(a_cnt_comp)
    );

    rvc_compressor #(.ENABLE_COMPRESS(1'b0), .COUNT_W(16), .PAD_HALF(16'h0001)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ins(b_in_ins), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .err_illegal(b_err), .cnt_in(b_cnt_in), .cnt_comp(b_cnt_comp)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Monitors: every handshaken output word is matched against the head of its queue.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (exp_a.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL word_a: got %08h expected nothing", a_out_data);
            end else begin
                check("word_a", a_out_data, exp_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (exp_b.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL word_b: got %08h expected nothing", b_out_data);
            end else begin
                check("word_b", b_out_data, exp_b.pop_front());
            end
        end
    end

    // Called away from a clock edge; in_ready depends only on registers and out_ready.
    task automatic send(input bit sel, input logic [31:0] ins, input logic last);
        logic rdy;
        bit   done;
        done = 1'b0;
        if (sel) begin b_in_valid = 1'b1; b_in_ins = ins; b_in_last = last; end
        else     begin a_in_valid = 1'b1; a_in_ins = ins; a_in_last = last; end
        for (int k = 0; k < 64 && !done; k++) begin
            rdy = sel ? b_in_ready : a_in_ready;
            @(posedge clk);
            #1;
            if (rdy) done = 1'b1;
        end
        a_in_valid = 1'b0; a_in_last = 1'b0;
        b_in_valid = 1'b0; b_in_last = 1'b0;
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout: ins %08h got no in_ready expected in_ready=1", ins);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && (exp_a.size() != 0 || exp_b.size() != 0); k++) tick(1);
        check("drain_a", 32'(exp_a.size()), 32'd0);
        check("drain_b", 32'(exp_b.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_ins = 32'd0; a_in_last = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_ins = 32'd0; b_in_last = 1'b0; b_out_ready = 1'b1;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, a_in_ready},  32'd1);
        check("rst_err",       {31'd0, a_err},       32'd0);
        check("rst_cnt_in",    {16'd0, a_cnt_in},    32'd0);
        check("rst_cnt_comp",  {16'd0, a_cnt_comp},  32'd0);

        // Two compressed halves pack into one word.
        exp_a.push_back(32'h41440405);
        send(0, 32'h00140413, 1'b0);
        send(0, 32'h00452483, 1'b0);
        drain();
        check("cnt_comp_pair", {16'd0, a_cnt_comp}, 32'd2);

        // Aligned 32-bit passes through with one cycle of latency.
        exp_a.push_back(32'h008000EF);
        send(0, 32'h008000EF, 1'b0);
        @(negedge clk);
        check("latency_valid", {31'd0, a_out_valid}, 32'd1);
        drain();
        check("cnt_comp_jal", {16'd0, a_cnt_comp}, 32'd2);

        // Misaligned 32-bit with in_last forces a padded flush word.
        exp_a.push_back(32'h00EF0405);
        exp_a.push_back(32'h00010080);
        send(0, 32'h00140413, 1'b0);
        send(0, 32'h008000EF, 1'b1);
        drain();
        @(negedge clk);
        check("flush_in_ready", {31'd0, a_in_ready}, 32'd1);

        // One word per pair of compressible encodings.
        exp_a.push_back(32'h08007139);  // c.addi16sp -64 ; c.addi4spn x8,16
        exp_a.push_back(32'h6785557D);  // c.li x10,-1 ; c.lui x15,1
        exp_a.push_back(32'h40B2050A);  // c.slli x10,2 ; c.lwsp x1,12
        exp_a.push_back(32'h8082C606);  // c.swsp x1,12 ; c.jr x1
        exp_a.push_back(32'h848D8C05);  // c.sub x8,x9 ; c.srai x9,3
        exp_a.push_back(32'h8CE99002);  // c.ebreak ; c.and x9,x10
        send(0, 32'hFC010113, 1'b0); send(0, 32'h01010413, 1'b0);
        send(0, 32'hFFF00513, 1'b0); send(0, 32'h000017B7, 1'b0);
        send(0, 32'h00251513, 1'b0); send(0, 32'h00C12083, 1'b0);
        send(0, 32'h00112623, 1'b0); send(0, 32'h00008067, 1'b0);
        send(0, 32'h40940433, 1'b0); send(0, 32'h4034D493, 1'b0);
        send(0, 32'h00100073, 1'b0); send(0, 32'h00A4F4B3, 1'b0);
        drain();

        // Range boundaries: imm -32 compresses, +32 and lw offset 128 do not; last with H empty.
        exp_a.push_back(32'h04131401);
        exp_a.push_back(32'h24830204);
        exp_a.push_back(32'h829A0805);
        send(0, 32'hFE040413, 1'b0);
        send(0, 32'h02040413, 1'b0);
        send(0, 32'h08052483, 1'b0);
        send(0, 32'h006002B3, 1'b1);
        drain();
        tick(2);
        @(negedge clk);
        check("no_flush_valid", {31'd0, a_out_valid}, 32'd0);
        exp_a.push_back(32'h00000097);  // auipc is never compressed
        send(0, 32'h00000097, 1'b0);
        drain();
        check("cnt_in_total",   {16'd0, a_cnt_in},   32'd22);
        check("cnt_comp_total", {16'd0, a_cnt_comp}, 32'd17);
        check("err_a_clear",    {31'd0, a_err},      32'd0);

        // Backpressure: the pending word must stay put and block the input.
        a_out_ready = 1'b0;
        send(0, 32'h006002B3, 1'b0);
        send(0, 32'h006002B3, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid",    {31'd0, a_out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, a_in_ready},  32'd0);
            check("bp_data",     a_out_data,           32'h829A829A);
        end
        exp_a.push_back(32'h829A829A);
        tick(1);
        a_out_ready = 1'b1;
        drain();

        // Reset with an unaccepted word pending discards it.
        a_out_ready = 1'b0;
        send(0, 32'h006002B3, 1'b0);
        send(0, 32'h006002B3, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        check("rst_pending_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_pending_cnt",   {16'd0, a_cnt_in},    32'd0);

        // Reset with a held halfword discards it.
        send(0, 32'h006002B3, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_a.push_back(32'h008000EF);
        send(0, 32'h008000EF, 1'b0);
        drain();

        // Pass-through instance: no compression, sticky illegal flag.
        exp_b.push_back(32'h00140413);
        exp_b.push_back(32'h00000405);
        send(1, 32'h00140413, 1'b0);
        send(1, 32'h00000405, 1'b0);
        tick(1);
        check("err_b_set", {31'd0, b_err}, 32'd1);
        exp_b.push_back(32'h00140413);
        send(1, 32'h00140413, 1'b0);
        drain();
        check("err_b_sticky", {31'd0, b_err},      32'd1);
        check("cnt_b_comp",   {16'd0, b_cnt_comp}, 32'd0);
        check("cnt_b_in",     {16'd0, b_cnt_in},   32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
